uart_apb_regs: RTL and testbench

Parametrised APB3 register file for the UART: the next generation of the UART register block, with the full 16550-style map. It adds divisor latch access, a programmable wait-state count, slave error reporting, sticky clear-on-read line status, and a prioritised interrupt identification register. It sits between the APB fabric and the UART TX/RX datapath and baud generator. It drives the control fields and the FIFO strobes, and collects status from the datapath.

---
 rtl/uart_apb_regs.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_apb_regs.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 register file for the UART (16550-style map).
// Holds the divisor latch, LCR/IER/MCR/FCR control, sticky line status
// and a prioritised interrupt ID. The transfer phase is tracked by an
// IDLE/SETUP/ACCESS FSM with WAIT_STATES extra access cycles.
// Optional feature: define UART_REGS_SCR_EN to implement the scratch
// register at offset 7; otherwise offset 7 reads 0 and ignores writes.
module uart_apb_regs #(
    parameter int WAIT_STATES = 0,
    parameter int DIV_W       = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [2:0]       PADDR,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [7:0]       PWDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [7:0]       PRDATA,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_fifo_empty,
    input  logic             i_tx_fifo_empty,
    input  logic             i_rx_ovr_run_err,
    input  logic             i_rx_parity_err,
    input  logic             i_rx_framing_err,
    input  logic             i_rx_break,
    output logic             o_tx_wr,
    output logic             o_rx_rd,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_fifo_clr,
    output logic             o_rx_fifo_clr,
    output logic             o_fifo_en,
    output logic [1:0]       o_rx_trig,
    output logic [7:0]       o_lcr,
    output logic [DIV_W-1:0] o_divisor,
    output logic             o_irq
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             ready;

    logic [7:0]       lcr;
    logic [7:0]       dll;
    logic [DIV_W-9:0] dlm;
    logic [3:0]       ier;
    logic [4:0]       mcr;
    logic             fifo_en;
    logic [1:0]       rx_trig;
    logic [3:0]       lsr_err;   // {BI, FE, PE, OE}
    logic             thre;
    logic             tx_empty_q;
`ifdef UART_REGS_SCR_EN
    logic [7:0]       scr;
`endif

    logic             wr, rd, dlab;
    logic             wr_thr, wr_dll, wr_ier, wr_dlm, wr_fcr, wr_lcr, wr_mcr;
    logic             rd_rbr, rd_iir, rd_lsr;
    logic [7:0]       lsr;
    logic [3:0]       iid;
    logic [7:0]       iir;
    logic             thre_set, thre_clr;

    // Phase register and access-cycle counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next phase; SETUP with PENABLE high is the first access cycle, so
    // WAIT_STATES=0 completes in two bus cycles
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) state_nxt = SETUP;
            end
            SETUP: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    if (WS == 4'd0) begin
                        ready     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = ACCESS;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (!PENABLE) begin
                    state_nxt = SETUP;
                end else if (cnt == WS) begin
                    ready     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr     = ready && PWRITE;
    assign rd     = ready && !PWRITE;
    assign dlab   = lcr[7];
    assign wr_thr = wr && PADDR == 3'd0 && !dlab;
    assign wr_dll = wr && PADDR == 3'd0 && dlab;
    assign wr_ier = wr && PADDR == 3'd1 && !dlab;
    assign wr_dlm = wr && PADDR == 3'd1 && dlab;
    assign wr_fcr = wr && PADDR == 3'd2;
    assign wr_lcr = wr && PADDR == 3'd3;
    assign wr_mcr = wr && PADDR == 3'd4;
    assign rd_rbr = rd && PADDR == 3'd0 && !dlab;
    assign rd_iir = rd && PADDR == 3'd2;
    assign rd_lsr = rd && PADDR == 3'd5;

    assign lsr = {|lsr_err[3:1], i_tx_fifo_empty, i_tx_fifo_empty, lsr_err, !i_rx_fifo_empty};

    // Interrupt priority: line status, RX data available, THR empty
    always_comb begin
        iid = 4'h1;
        if (lsr_err != 4'd0 && ier[2])         iid = 4'h6;
        else if (!i_rx_fifo_empty && ier[0])   iid = 4'h4;
        else if (thre)                         iid = 4'h2;
    end
    assign iir = {fifo_en, fifo_en, 2'b00, iid};

    // THRE is raised by TX draining or by enabling its interrupt while
    // already empty; a raise in the same cycle as a clear wins
    assign thre_set = (i_tx_fifo_empty && !tx_empty_q && ier[1]) ||
                      (wr_ier && PWDATA[1] && !ier[1] && i_tx_fifo_empty);
    assign thre_clr = wr_thr || (rd_iir && iid == 4'h2);

    // Control registers written in the PREADY cycle
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lcr     <= 8'h03;
            dll     <= 8'h01;
            dlm     <= '0;
            ier     <= 4'h0;
            mcr     <= 5'h00;
            fifo_en <= 1'b0;
            rx_trig <= 2'b00;
        end else begin
            if (wr_lcr) lcr <= PWDATA;
            if (wr_dll) dll <= PWDATA;
            if (wr_dlm) dlm <= PWDATA[DIV_W-9:0];
            if (wr_ier) ier <= PWDATA[3:0];
            if (wr_mcr) mcr <= PWDATA[4:0];
            if (wr_fcr) begin
                fifo_en <= PWDATA[0];
                rx_trig <= PWDATA[7:6];
            end
        end
    end

    // Sticky line errors and THRE pending; a new pulse beats an LSR read clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lsr_err    <= 4'h0;
            thre       <= 1'b0;
            tx_empty_q <= 1'b0;
        end else begin
            lsr_err    <= (rd_lsr ? 4'h0 : lsr_err) |
                          {i_rx_break, i_rx_framing_err, i_rx_parity_err, i_rx_ovr_run_err};
            thre       <= thre_set || (thre && !thre_clr);
            tx_empty_q <= i_tx_fifo_empty;
        end
    end

`ifdef UART_REGS_SCR_EN
    // Scratch register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                         scr <= 8'h00;
        else if (wr && PADDR == 3'd7)         scr <= PWDATA;
    end
`endif

    // Read data mux, driven only during a read PREADY cycle
    always_comb begin
        PRDATA = 8'h00;
        if (rd) begin
            case (PADDR)
                3'd0: PRDATA = dlab ? dll : i_rx_data;
                3'd1: PRDATA = dlab ? 8'(dlm) : {4'h0, ier};
                3'd2: PRDATA = iir;
                3'd3: PRDATA = lcr;
                3'd4: PRDATA = {3'b000, mcr};
                3'd5: PRDATA = lsr;
`ifdef UART_REGS_SCR_EN
                3'd7: PRDATA = scr;
`endif
                default: PRDATA = 8'h00;
            endcase
        end
    end

    assign PREADY        = ready;
    assign PSLVERR       = wr && (PADDR == 3'd5 || PADDR == 3'd6);
    assign o_tx_wr       = wr_thr;
    assign o_tx_data     = wr_thr ? PWDATA : 8'h00;
    assign o_rx_rd       = rd_rbr && !i_rx_fifo_empty;
    assign o_rx_fifo_clr = wr_fcr && PWDATA[1];
    assign o_tx_fifo_clr = wr_fcr && PWDATA[2];
    assign o_fifo_en     = fifo_en;
    assign o_rx_trig     = rx_trig;
    assign o_lcr         = lcr;
    assign o_divisor     = {dlm, dll};
    assign o_irq         = !iid[0];

endmodule

// File: tb/tb_uart_apb_regs.sv
// tb_uart_apb_regs: randomized APB traffic against a behavioural model of
// the UART register map; a monitor pops expected responses per PREADY.
`timescale 1ns/1ps
module tb_uart_apb_regs;

    localparam int WS = 3;
    localparam int DW = 16;
`ifdef UART_REGS_SCR_EN
    localparam logic [7:0] SCR_EXP = 8'hA5;
`else
    localparam logic [7:0] SCR_EXP = 8'h00;
`endif

    logic          PCLK = 1'b0, PRESETn = 1'b0;
    logic [2:0]    PADDR = '0;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]    PWDATA = '0;
    logic          PREADY, PSLVERR;
    logic [7:0]    PRDATA;
    logic [7:0]    i_rx_data = 8'h00;
    logic          i_rx_fifo_empty = 1'b1, i_tx_fifo_empty = 1'b1;
    logic          i_rx_ovr_run_err = 1'b0, i_rx_parity_err = 1'b0;
    logic          i_rx_framing_err = 1'b0, i_rx_break = 1'b0;
    logic          o_tx_wr, o_rx_rd, o_tx_fifo_clr, o_rx_fifo_clr, o_fifo_en, o_irq;
    logic [7:0]    o_tx_data, o_lcr;
    logic [1:0]    o_rx_trig;
    logic [DW-1:0] o_divisor;

    always #5 PCLK = ~PCLK;

    uart_apb_regs #(.WAIT_STATES(WS), .DIV_W(DW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
        .i_rx_data(i_rx_data), .i_rx_fifo_empty(i_rx_fifo_empty),
        .i_tx_fifo_empty(i_tx_fifo_empty), .i_rx_ovr_run_err(i_rx_ovr_run_err),
        .i_rx_parity_err(i_rx_parity_err), .i_rx_framing_err(i_rx_framing_err),
        .i_rx_break(i_rx_break), .o_tx_wr(o_tx_wr), .o_rx_rd(o_rx_rd),
        .o_tx_data(o_tx_data), .o_tx_fifo_clr(o_tx_fifo_clr),
        .o_rx_fifo_clr(o_rx_fifo_clr), .o_fifo_en(o_fifo_en),
        .o_rx_trig(o_rx_trig), .o_lcr(o_lcr), .o_divisor(o_divisor), .o_irq(o_irq)
    );

    typedef struct packed {
        logic [7:0] rdata;
        logic       slverr;
        logic       tx_wr;
        logic       rx_rd;
        logic       txclr;
        logic       rxclr;
        logic [7:0] txd;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   rx_rd_cnt = 0;
    exp_t expq[$];
    exp_t mon_e, mon_a;

    // reference model state
    logic [7:0] m_lcr, m_dll, m_dlm, m_scr;
    logic [3:0] m_ier;
    logic [4:0] m_mcr;
    logic       m_fen;
    logic [1:0] m_trig;
    logic [3:0] m_err;   // OE, PE, FE, BI at indices 0..3
    logic       m_thre;

    function automatic void m_reset();
        m_lcr = 8'h03; m_dll = 8'h01; m_dlm = 8'h00; m_scr = 8'h00;
        m_ier = 4'h0; m_mcr = 5'h00; m_fen = 1'b0; m_trig = 2'b00;
        m_err = 4'h0; m_thre = 1'b0;
    endfunction

    function automatic logic [7:0] m_lsr();
        return {(m_err[1] | m_err[2] | m_err[3]), i_tx_fifo_empty, i_tx_fifo_empty,
                m_err, ~i_rx_fifo_empty};
    endfunction

    function automatic logic [3:0] m_iid();
        if (m_err != 4'h0 && m_ier[2])        return 4'h6;
        if (!i_rx_fifo_empty && m_ier[0])     return 4'h4;
        if (m_thre)                           return 4'h2;
        return 4'h1;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_lcr[7] ? m_dll : i_rx_data;
            3'd1: return m_lcr[7] ? m_dlm : {4'h0, m_ier};
            3'd2: return {m_fen, m_fen, 2'b00, m_iid()};
            3'd3: return m_lcr;
            3'd4: return {3'b000, m_mcr};
            3'd5: return m_lsr();
`ifdef UART_REGS_SCR_EN
            3'd7: return m_scr;
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: every PREADY cycle pops one expected response
    always @(negedge PCLK) begin
        if (PRESETn) begin
            mon_a = {PRDATA, PSLVERR, o_tx_wr, o_rx_rd, o_tx_fifo_clr, o_rx_fifo_clr, o_tx_data};
            if (PREADY) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pready: got %0h want none", mon_a);
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_a !== mon_e) begin
                        miscompares++;
                        $display("FAIL xfer_resp addr=%0d: got %h want %h", PADDR, mon_a, mon_e);
                    end
                end
            end else if (mon_a != '0) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_outputs: got %h want 0", mon_a);
            end
        end
    end

    always @(posedge PCLK) if (o_rx_rd) rx_rd_cnt <= rx_rd_cnt + 1;

    task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       input bit pe_at_rdy, output logic [7:0] rdata);
        exp_t e;
        int n;
        logic dlab;
        logic [3:0] iid;
        dlab     = m_lcr[7];
        iid      = m_iid();
        e        = '0;
        e.slverr = wr && (a == 3'd5 || a == 3'd6);
        if (!wr) e.rdata = m_read(a);
        e.tx_wr  = wr && a == 3'd0 && !dlab;
        e.txd    = e.tx_wr ? d : 8'h00;
        e.rx_rd  = !wr && a == 3'd0 && !dlab && !i_rx_fifo_empty;
        e.txclr  = wr && a == 3'd2 && d[2];
        e.rxclr  = wr && a == 3'd2 && d[1];
        expq.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 16);
        chk("pready_latency", n, WS + 1);
        rdata = PRDATA;
        if (!PREADY) void'(expq.pop_back());
        if (pe_at_rdy) i_rx_parity_err = 1'b1;
        if (wr) begin
            case (a)
                3'd0: if (dlab) m_dll = d; else m_thre = 1'b0;
                3'd1: begin
                    if (dlab) m_dlm = 8'(int'(d) % (1 << (DW - 8)));
                    else begin
                        if (d[1] && !m_ier[1] && i_tx_fifo_empty) m_thre = 1'b1;
                        m_ier = d[3:0];
                    end
                end
                3'd2: begin m_fen = d[0]; m_trig = d[7:6]; end
                3'd3: m_lcr = d;
                3'd4: m_mcr = d[4:0];
                3'd7: m_scr = d;
                default: ;
            endcase
        end else begin
            if (a == 3'd2 && iid == 4'h2) m_thre = 1'b0;
            if (a == 3'd5) m_err = 4'h0;
        end
        if (pe_at_rdy) m_err[1] = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; i_rx_parity_err = 1'b0;
    endtask

    task automatic pulse(input int idx);
        @(posedge PCLK); #1;
        case (idx)
            0: i_rx_ovr_run_err = 1'b1;
            1: i_rx_parity_err = 1'b1;
            2: i_rx_framing_err = 1'b1;
            default: i_rx_break = 1'b1;
        endcase
        m_err[idx] = 1'b1;
        @(posedge PCLK); #1;
        {i_rx_ovr_run_err, i_rx_parity_err, i_rx_framing_err, i_rx_break} = 4'h0;
    endtask

    task automatic set_tx(input logic v);
        @(posedge PCLK); #1;
        if (v && !i_tx_fifo_empty && m_ier[1]) m_thre = 1'b1;
        i_tx_fifo_empty = v;
        @(posedge PCLK); #1;
    endtask

    task automatic set_rx(input logic empty, input logic [7:0] data);
        @(posedge PCLK); #1;
        i_rx_fifo_empty = empty;
        i_rx_data = data;
    endtask

    task automatic check_outs();
        @(negedge PCLK);
        chk("o_lcr", o_lcr, m_lcr);
        chk("o_divisor", o_divisor, {m_dlm, m_dll});
        chk("o_irq", o_irq, m_iid() != 4'h1);
        chk("o_fifo_en", o_fifo_en, m_fen);
        chk("o_rx_trig", o_rx_trig, m_trig);
    endtask

    initial begin
        logic [7:0] rd;
        int n0;
        m_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_lcr", o_lcr, 8'h03);
        chk("rst_divisor", o_divisor, 1);
        chk("rst_irq", o_irq, 0);
        chk("rst_pready", PREADY, 0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        apb(0, 3'd3, 8'h00, 0, rd); chk("rst_read_lcr", rd, 8'h03);
        apb(0, 3'd2, 8'h00, 0, rd); chk("rst_read_iir", rd, 8'h01);
        check_outs();

        // divisor latch then THR write
        apb(1, 3'd3, 8'h83, 0, rd);
        apb(1, 3'd0, 8'h34, 0, rd);
        apb(1, 3'd1, 8'h12, 0, rd);
        apb(1, 3'd3, 8'h03, 0, rd);
        chk("divisor_1234", o_divisor, 16'h1234);
        apb(1, 3'd0, 8'h55, 0, rd);
        check_outs();

        // aborted RBR read: no FIFO pop
        set_rx(1'b0, 8'h3C);
        n0 = rx_rd_cnt;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(posedge PCLK);
        chk("abort_no_rx_rd", rx_rd_cnt, n0);
        apb(0, 3'd0, 8'h00, 0, rd); chk("rbr_data", rd, 8'h3C);
        @(posedge PCLK);
        chk("rbr_rx_rd_once", rx_rd_cnt, n0 + 1);

        // interrupt priority and LSR clear-on-read
        set_tx(1'b0);
        apb(1, 3'd1, 8'h05, 0, rd);
        pulse(1);
        apb(0, 3'd2, 8'h00, 0, rd); chk("iir_line", rd, 8'h06);
        chk("irq_line", o_irq, 1);
        apb(0, 3'd5, 8'h00, 0, rd); chk("lsr_85", rd, 8'h85);
        apb(0, 3'd2, 8'h00, 0, rd); chk("iir_rxdata", rd, 8'h04);

        // error pulse coinciding with the clearing read
        pulse(1);
        apb(0, 3'd5, 8'h00, 1, rd);
        apb(0, 3'd5, 8'h00, 0, rd); chk("lsr_pe_kept", rd[2], 1);
        apb(0, 3'd5, 8'h00, 0, rd); chk("lsr_pe_cleared", rd[2], 0);

        // illegal writes, scratch, FCR
        apb(1, 3'd5, 8'hFF, 0, rd);
        apb(1, 3'd6, 8'hFF, 0, rd);
        apb(0, 3'd5, 8'h00, 0, rd); chk("lsr_unchanged", rd, 8'h01);
        apb(1, 3'd7, 8'hA5, 0, rd);
        apb(0, 3'd7, 8'h00, 0, rd); chk("scr_readback", rd, SCR_EXP);
        apb(1, 3'd2, 8'hC7, 0, rd);
        check_outs();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5:
                    apb(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        8'($urandom), 0, rd);
                6: pulse($urandom_range(0, 3));
                7: set_tx(1'($urandom_range(0, 1)));
                8: set_rx(1'($urandom_range(0, 1)), 8'($urandom));
                default: check_outs();
            endcase
        end
        check_outs();

        // reset in the middle of an LCR write
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd3; PWDATA = 8'h1F;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(negedge PCLK); PRESETn = 1'b0;
        @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        m_reset();
        @(negedge PCLK);
        chk("rst_mid_pready", PREADY, 0);
        @(posedge PCLK); #1; PRESETn = 1'b1;
        check_outs();
        apb(0, 3'd3, 8'h00, 0, rd); chk("rst_mid_lcr", rd, 8'h03);

        repeat (2) @(posedge PCLK);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
